alu_datapath: RTL and testbench
===============================

Name: alu_datapath

Overview:
Two-operand execution datapath for the CPU core. It holds two word-wide operand registers, T1 and T2, each with its own write enable and output enable. A combinational ALU operates on the two register outputs and produces a result word and a 5-bit flag vector. The CPU FSM drives all enables and the opcode directly.

Parameters:
WORD_WIDTH, 32, width of operands, registers and result.
FLAG_WIDTH, 5, width of the flag vector; fixed at 5 in this spec.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  reset; asynchronous, active-low (rst=0 resets).
t1_we  input  1  load T1 from t1_in on the rising clk edge.
t1_oe  input  1  drive T1 contents onto t1_out.
t1_in  input  WORD_WIDTH  T1 write data.
t1_out  output  WORD_WIDTH  T1 contents when t1_oe=1, else 0.
t2_we  input  1  load T2 from t2_in on the rising clk edge.
t2_oe  input  1  drive T2 contents onto t2_out.
t2_in  input  WORD_WIDTH  T2 write data.
t2_out  output  WORD_WIDTH  T2 contents when t2_oe=1, else 0.
alu_oe  input  1  enable for the ALU result and flags.
alu_opcode  input  4  operation select.
alu_carry  input  1  carry/borrow in for ADC/SBB.
alu_out  output  WORD_WIDTH  result when alu_oe=1, else 0.
alu_flags  output  FLAG_WIDTH  {V,N,C,P,Z} bits [4:0] when alu_oe=1, else 0.

Behaviour:
- Register reset: rst=0 asynchronously clears T1 and T2 to 0. While reset is held, all outputs are 0.
- Register write: on a clk rise with we=1, the register captures its input. Write latency is 1 cycle; the new value is visible the cycle after.
- Register hold: we=0 holds the stored value.
- Independent registers: T1 and T2 load independently; both may load in the same cycle.
- Output enable: oe only gates the output (out = oe ? stored : 0). It never alters stored contents. we and oe together in one cycle: out shows the old value until the edge.
- ALU inputs: operands A=t1_out and B=t2_out, after gating. A disabled register therefore presents 0 to the ALU.
- ALU timing: purely combinational; zero latency.
- Opcodes:
  0 ADD A+B
  1 ADC A+B+carry
  2 SUB A-B
  3 SBB A-B-carry
  4 AND
  5 OR
  6 XOR
  7 NOT A
  8 SHL A<<B[4:0]
  9 SHR logical
  10 SAR arithmetic
  11 ROL
  12 ROR
  13 PASS A
  14 PASS B
  15 INC A+1
- Shift and rotate amounts use B modulo WORD_WIDTH (low log2(WORD_WIDTH) bits).
- Arithmetic width: results are computed in WORD_WIDTH+1 bits and truncated to WORD_WIDTH; wrap-around is modulo 2^WORD_WIDTH.
- Flag Z: result==0.
- Flag P: even parity of the result (XNOR-reduce).
- Flag C: carry-out for ADD/ADC/INC; borrow for SUB/SBB; last bit shifted out for SHL/SHR/SAR; bit rotated through for ROL/ROR (0 when the amount is 0); 0 for logic and pass ops.
- Flag N: result MSB.
- Flag V: signed overflow for ADD/ADC/SUB/SBB/INC; 0 otherwise.
- Boundary: 0xFFFFFFFF+1 gives 0 with Z=1, C=1, V=0. 0x7FFFFFFF+1 gives 0x80000000 with V=1, N=1. 0-1 gives 0xFFFFFFFF with C=1 (borrow).

Optional Feature:
ALU_RESULT_REG_EN
- Defined: alu_out and alu_flags are captured in a pipeline register on the rising clk edge, giving 1-cycle ALU latency. The register is cleared asynchronously by rst=0. alu_oe gates the captured value at the output.
- Undefined: the ALU is fully combinational as specified above.

Decomposition:
- Shared package: the 16 opcode localparams (ALU_ADD..ALU_INC) and the flag bit indices (FLAG_Z=0, FLAG_P=1, FLAG_C=2, FLAG_N=3, FLAG_V=4).
- One sub-module: data_reg, a parameterised word register with clk, rst, oe, we, in, out. It is instantiated twice, for T1 and T2.
- ALU logic sits inline in alu_datapath as a single combinational case block.

Test Plan:
1. Reset then load: pulse rst low, then load T1=5 and T2=6 in the same cycle; next cycle with both oe=1 -> t1_out=5, t2_out=6; ADD gives alu_out=11 with Z=0, C=0.
2. Output enable gating: t1_oe=0 with T1 holding 5 -> t1_out=0, and PASS A gives alu_out=0 with Z=1; raise oe -> t1_out=5 again, proving contents were retained.
3. Arithmetic edges: A=0xFFFFFFFF, B=1, ADD -> 0, Z=1, C=1. A=0x7FFFFFFF, INC -> 0x80000000, V=1, N=1. A=0, B=1, SUB -> 0xFFFFFFFF, C=1.
4. Shifts and rotates: A=0x80000001, B=33 (amount 1). SHL -> 0x00000002, C=1. SAR -> 0xC0000000, C=1. ROR -> 0xC0000000.
5. Asynchronous reset mid-operation: load T1=0x1234, then drop rst between clock edges -> t1_out=0 immediately; a we asserted during reset has no effect.
6. Carry-in and alu_oe: A=10, B=3, alu_carry=1. ADC -> 14. SBB -> 6. With alu_oe=0 -> alu_out=0 and alu_flags=0.

Source files
------------

// File: rtl/alu_datapath_pkg.sv
// alu_datapath_pkg: opcode encodings and flag bit positions shared by the datapath
package alu_datapath_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADC  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SBB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOT  = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_SHR  = 4'd9;
    localparam logic [3:0] ALU_SAR  = 4'd10;
    localparam logic [3:0] ALU_ROL  = 4'd11;
    localparam logic [3:0] ALU_ROR  = 4'd12;
    localparam logic [3:0] ALU_PASA = 4'd13;
    localparam logic [3:0] ALU_PASB = 4'd14;
    localparam logic [3:0] ALU_INC  = 4'd15;
    localparam int FLAG_Z = 0;
    localparam int FLAG_P = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_V = 4;
endpackage

// File: rtl/alu_datapath_data_reg.sv
// data_reg: word register with load enable and output gating (gating never touches contents)
module data_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe,
    input  logic             we,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] q;
    // storage: async active-low clear, load on we
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (we) q <= in;
    end
    assign out = oe ? q : '0;
endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: T1/T2 operand registers feeding a 16-op ALU; ALU_RESULT_REG_EN adds a result register
module alu_datapath
    import alu_datapath_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int FLAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  t1_we,
    input  logic                  t1_oe,
    input  logic [WORD_WIDTH-1:0] t1_in,
    output logic [WORD_WIDTH-1:0] t1_out,
    input  logic                  t2_we,
    input  logic                  t2_oe,
    input  logic [WORD_WIDTH-1:0] t2_in,
    output logic [WORD_WIDTH-1:0] t2_out,
    input  logic                  alu_oe,
    input  logic [3:0]            alu_opcode,
    input  logic                  alu_carry,
    output logic [WORD_WIDTH-1:0] alu_out,
    output logic [FLAG_WIDTH-1:0] alu_flags
);
    localparam int SW = $clog2(WORD_WIDTH);
    localparam int MSB = WORD_WIDTH - 1;
    logic [WORD_WIDTH-1:0] a, b, bop, res;
    logic [WORD_WIDTH:0]   sum, sr;
    logic [FLAG_WIDTH-1:0] flg;
    logic [SW-1:0]         sh;
    logic                  arith, c_f;

    data_reg #(.WIDTH(WORD_WIDTH)) u_t1 (.clk(clk), .rst(rst), .oe(t1_oe), .we(t1_we), .in(t1_in), .out(t1_out));
    data_reg #(.WIDTH(WORD_WIDTH)) u_t2 (.clk(clk), .rst(rst), .oe(t2_oe), .we(t2_we), .in(t2_in), .out(t2_out));

    assign a = t1_out;
    assign b = t2_out;
    assign sh = b[SW-1:0];
    assign arith = alu_opcode inside {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_INC};

    // ALU: arithmetic in W+1 bits so bit W is carry/borrow; shifts carry an extra bit to catch the last bit out
    always_comb begin
        sum = '0;
        sr  = '0;
        bop = b;
        res = '0;
        c_f = 1'b0;
        case (alu_opcode)
            ALU_ADD:  sum = {1'b0, a} + {1'b0, b};
            ALU_ADC:  sum = {1'b0, a} + {1'b0, b} + {{WORD_WIDTH{1'b0}}, alu_carry};
            ALU_SUB:  begin sum = {1'b0, a} - {1'b0, b}; bop = ~b; end
            ALU_SBB:  begin sum = {1'b0, a} - {1'b0, b} - {{WORD_WIDTH{1'b0}}, alu_carry}; bop = ~b; end
            ALU_INC:  begin sum = {1'b0, a} + {{WORD_WIDTH{1'b0}}, 1'b1}; bop = '0; end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOT:  res = ~a;
            ALU_SHL:  begin sr = {1'b0, a} << sh; res = sr[MSB:0]; c_f = sr[WORD_WIDTH]; end
            ALU_SHR:  begin sr = {a, 1'b0} >> sh; res = sr[WORD_WIDTH:1]; c_f = sr[0]; end
            ALU_SAR:  begin sr = $signed({a, 1'b0}) >>> sh; res = sr[WORD_WIDTH:1]; c_f = sr[0]; end
            ALU_ROL:  begin res = (a << sh) | (a >> (WORD_WIDTH - int'(sh))); c_f = (sh != '0) && res[0]; end
            ALU_ROR:  begin res = (a >> sh) | (a << (WORD_WIDTH - int'(sh))); c_f = (sh != '0) && res[MSB]; end
            ALU_PASA: res = a;
            ALU_PASB: res = b;
        endcase
        if (arith) begin
            res = sum[MSB:0];
            c_f = sum[WORD_WIDTH];
        end
        flg = '0;
        flg[FLAG_Z] = ~|res;
        flg[FLAG_P] = ~^res;
        flg[FLAG_C] = c_f;
        flg[FLAG_N] = res[MSB];
        flg[FLAG_V] = arith && (a[MSB] == bop[MSB]) && (res[MSB] != a[MSB]);
    end

`ifdef ALU_RESULT_REG_EN
    logic [WORD_WIDTH-1:0] res_q;
    logic [FLAG_WIDTH-1:0] flg_q;
    // result pipeline stage: captures raw ALU output every cycle, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
            flg_q <= '0;
        end else begin
            res_q <= res;
            flg_q <= flg;
        end
    end
    assign alu_out   = (alu_oe && rst) ? res_q : '0;
    assign alu_flags = (alu_oe && rst) ? flg_q : '0;
`else
    assign alu_out   = (alu_oe && rst) ? res : '0;
    assign alu_flags = (alu_oe && rst) ? flg : '0;
`endif
endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: scoreboard bench for alu_datapath (directed plan plus random traffic)
module tb_alu_datapath;
    import alu_datapath_pkg::*;

    typedef struct packed {
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] ao;
        logic [4:0]  fl;
        logic [15:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        t1_we = 1'b0, t1_oe = 1'b0, t2_we = 1'b0, t2_oe = 1'b0;
    logic        alu_oe = 1'b0, alu_carry = 1'b0;
    logic [3:0]  alu_opcode = 4'd0;
    logic [31:0] t1_in = '0, t2_in = '0;
    logic [31:0] t1_out, t2_out, alu_out;
    logic [4:0]  alu_flags;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          step = 0;
    logic [31:0] m1 = '0, m2 = '0;
    logic [36:0] regv = '0;

    alu_datapath dut (
        .clk(clk), .rst(rst),
        .t1_we(t1_we), .t1_oe(t1_oe), .t1_in(t1_in), .t1_out(t1_out),
        .t2_we(t2_we), .t2_oe(t2_oe), .t2_in(t2_in), .t2_out(t2_out),
        .alu_oe(alu_oe), .alu_opcode(alu_opcode), .alu_carry(alu_carry),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference ALU from the opcode definitions: wide integer math, bit-at-a-time shifts. Returns {V,N,C,P,Z,result}.
    function automatic logic [36:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic c);
        longint unsigned ua, ub, s;
        longint sa, sb, st;
        logic [31:0] r;
        logic cf, vf;
        int n;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        n = int'(b[4:0]); s = 0; st = 0; r = a; cf = 1'b0; vf = 1'b0;
        case (op)
            ALU_ADD:  begin s = ua + ub; st = sa + sb; end
            ALU_ADC:  begin s = ua + ub + c; st = sa + sb + longint'(c); end
            ALU_SUB:  begin s = ua - ub; st = sa - sb; end
            ALU_SBB:  begin s = ua - ub - c; st = sa - sb - longint'(c); end
            ALU_INC:  begin s = ua + 1; st = sa + 1; end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOT:  r = ~a;
            ALU_SHL:  for (int i = 0; i < n; i++) begin cf = r[31]; r = r << 1; end
            ALU_SHR:  for (int i = 0; i < n; i++) begin cf = r[0]; r = r >> 1; end
            ALU_SAR:  for (int i = 0; i < n; i++) begin cf = r[0]; r = {r[31], r[31:1]}; end
            ALU_ROL:  for (int i = 0; i < n; i++) begin r = {r[30:0], r[31]}; cf = r[0]; end
            ALU_ROR:  for (int i = 0; i < n; i++) begin r = {r[0], r[31:1]}; cf = r[31]; end
            ALU_PASA: r = a;
            ALU_PASB: r = b;
        endcase
        if (op inside {ALU_ADD, ALU_ADC, ALU_INC}) begin r = s[31:0]; cf = ua + ub * (op != ALU_INC) + (op == ALU_ADC ? c : 0) + (op == ALU_INC) > 64'hFFFF_FFFF; end
        if (op inside {ALU_SUB, ALU_SBB}) begin r = s[31:0]; cf = ua < ub + (op == ALU_SBB ? c : 0); end
        if (op inside {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_INC}) vf = (st != longint'($signed(r)));
        return {vf, r[31], cf, ($countones(r) % 2 == 0), (r == 0), r};
    endfunction

    // One clock of stimulus: drive between edges, push the expected outputs, then advance the model across the edge.
    task automatic cyc(input logic rn, input logic we1, input logic oe1, input logic [31:0] in1,
                       input logic we2, input logic oe2, input logic [31:0] in2,
                       input logic aoe, input logic [3:0] op, input logic c);
        logic [31:0] a, b;
        logic [36:0] raw, shown;
        exp_t e;
        @(posedge clk);
        #1;
        rst = rn; t1_we = we1; t1_oe = oe1; t1_in = in1;
        t2_we = we2; t2_oe = oe2; t2_in = in2;
        alu_oe = aoe; alu_opcode = op; alu_carry = c;
        if (!rn) begin m1 = '0; m2 = '0; regv = '0; end
        a = oe1 ? m1 : '0;
        b = oe2 ? m2 : '0;
        raw = ref_alu(a, b, op, c);
`ifdef ALU_RESULT_REG_EN
        shown = regv;
`else
        shown = raw;
`endif
        step++;
        e.t1 = a; e.t2 = b;
        e.ao = (aoe && rn) ? shown[31:0] : '0;
        e.fl = (aoe && rn) ? shown[36:32] : '0;
        e.tag = 16'(step);
        q.push_back(e);
        if (rn) begin
            if (we1) m1 = in1;
            if (we2) m2 = in2;
            regv = raw;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int tag);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, exp);
        end
    endtask

    // Monitor: outputs are settled at the falling edge; compare against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("t1_out", t1_out, e.t1, int'(e.tag));
            chk("t2_out", t2_out, e.t2, int'(e.tag));
            chk("alu_out", alu_out, e.ao, int'(e.tag));
            chk("alu_flags", {27'b0, alu_flags}, {27'b0, e.fl}, int'(e.tag));
        end
    end

    initial begin
        // reset held: everything reads zero even with all enables up
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, ALU_INC, 1'b0);
        // load 5 and 6 together, then ADD
        cyc(1'b1, 1'b1, 1'b1, 32'd5, 1'b1, 1'b1, 32'd6, 1'b1, ALU_ADD, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_ADD, 1'b0);
        // output gating keeps contents
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_PASA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_PASA, 1'b0);
        // arithmetic boundaries
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd1, 1'b1, ALU_ADD, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'd0, 1'b1, ALU_ADD, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_INC, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_SUB, 1'b0);
        // shifts and rotates with amount 33 -> 1
        cyc(1'b1, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 1'b1, 32'd33, 1'b1, ALU_SUB, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_SHL, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_SAR, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_ROR, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_ROL, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_SHR, 1'b0);
        // async reset mid-operation; write during reset is ignored
        cyc(1'b1, 1'b1, 1'b1, 32'h1234, 1'b0, 1'b1, 32'd0, 1'b1, ALU_PASA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_PASA, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hCAFE, 1'b1, ALU_PASA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_PASA, 1'b0);
        // carry-in ops and alu_oe gating
        cyc(1'b1, 1'b1, 1'b1, 32'd10, 1'b1, 1'b1, 32'd3, 1'b1, ALU_ADD, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_ADC, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, ALU_SBB, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b0, ALU_SBB, 1'b1);
        // random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            logic [31:0] v1, v2;
            v1 = $urandom;
            v2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) v1 = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            cyc(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), v1,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), v2,
                1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
